// File: rtl/conv_1st_sched.sv
// Frame sequencer for the first-layer conv engine: loads bias and image
// buffers from valid/ready streams, starts the engine, forwards and counts
// its output beats, and reports frame completion or timeout.
module conv_1st_sched #(
  parameter int unsigned IMG_WORDS  = 75,
  parameter int unsigned BIAS_WORDS = 34,
  parameter int unsigned OUT_BEATS  = 32,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_req,
  input  logic         bias_reload,
  output logic         frame_busy,
  output logic         frame_done,
  output logic         err_timeout,
  input  logic         bias_valid,
  input  logic [15:0]  bias_data,
  output logic         bias_ready,
  input  logic         pix_valid,
  input  logic [31:0]  pix_data,
  output logic         pix_ready,
  output logic [39:0]  scan_o,
  output logic [23:0]  bias_o,
  output logic         sta_o,
  input  logic         conv_valid_i,
  input  logic [319:0] conv_data_i,
  output logic         out_valid,
  output logic [319:0] out_data,
  output logic [5:0]   beat_cnt
);

  localparam int unsigned WCNT_W = 7;
  localparam int unsigned BEAT_W = 6;
  localparam int unsigned RUN_W  = 12;

  // Idle pointers sit outside both engine buffers, so no write happens.
  localparam logic [23:0] BIAS_IDLE = {16'h0000, 2'b00, 6'h3F};
  localparam logic [39:0] SCAN_IDLE = {32'h0000_0000, 1'b0, 7'h7F};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIAS = 3'd1,
    LOAD_IMG  = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [WCNT_W-1:0]   word_cnt;
  logic [RUN_W-1:0]    run_cnt;
  logic                accept;
  logic                bias_hs;
  logic                pix_hs;
  logic                beat_hs;
  logic                last_beat;
  logic                timeout_hit;

  // Next-state decode and handshake qualification.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    bias_hs     = bias_valid & bias_ready;
    pix_hs      = pix_valid & pix_ready;
    beat_hs     = (state == RUN) && conv_valid_i;
    last_beat   = beat_hs && (beat_cnt == BEAT_W'(OUT_BEATS - 1));
    timeout_hit = (state == RUN) && (run_cnt >= RUN_W'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (frame_req) begin
          accept   = 1'b1;
          state_nx = bias_reload ? LOAD_BIAS : LOAD_IMG;
        end
      end
      LOAD_BIAS: begin
        if (bias_hs && (word_cnt == WCNT_W'(BIAS_WORDS - 1))) state_nx = LOAD_IMG;
      end
      LOAD_IMG: begin
        if (pix_hs && (word_cnt == WCNT_W'(IMG_WORDS - 1))) state_nx = RUN;
      end
      RUN: begin
        if (last_beat || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered status and stream-ready outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      sta_o      <= 1'b0;
      bias_ready <= 1'b0;
      pix_ready  <= 1'b0;
    end else begin
      frame_busy <= (state_nx != IDLE);
      frame_done <= (state_nx == DONE);
      sta_o      <= (state_nx == RUN);
      bias_ready <= (state_nx == LOAD_BIAS);
      pix_ready  <= (state_nx == LOAD_IMG);
    end
  end

  // Buffer write ports: one registered write per handshake, idle pointer otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_o <= BIAS_IDLE;
      scan_o <= SCAN_IDLE;
    end else begin
      bias_o <= bias_hs ? {bias_data, 2'b00, 6'(word_cnt)} : BIAS_IDLE;
      scan_o <= pix_hs ? {pix_data, 1'b0, word_cnt} : SCAN_IDLE;
    end
  end

  // Word counter: restarts on frame accept and at the end of each load phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= '0;
    end else if (bias_hs || pix_hs) begin
      word_cnt <= (state_nx != state) ? '0 : word_cnt + WCNT_W'(1);
    end
  end

  // Output forwarding, beat counting and the RUN watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      beat_cnt    <= '0;
      run_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      out_valid <= beat_hs;
      if (beat_hs) out_data <= conv_data_i;

      if (accept)                         beat_cnt <= '0;
      else if (beat_hs && (&beat_cnt == 1'b0)) beat_cnt <= beat_cnt + BEAT_W'(1);

      if (state != RUN)               run_cnt <= '0;
      else if (&run_cnt == 1'b0)      run_cnt <= run_cnt + RUN_W'(1);

      if (accept)                           err_timeout <= 1'b0;
      else if (timeout_hit && !last_beat)   err_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/conv_1st_sched.md
Name: conv_1st_sched

Overview:
Frame-level sequencer for the first-layer convolution engine. It streams bias/rescale words and image words from upstream valid/ready interfaces into the engine's pointer-addressed bias and scan buffers, then raises sta. It counts the engine's output beats, forwards them downstream and reports frame completion or timeout. It sits directly between the input DMA/stream logic and the conv engine top.

Parameters:
IMG_WORDS, 75, 32-bit image words per frame (4 pixels each), written to scan pointers 0..IMG_WORDS-1
BIAS_WORDS, 34, 16-bit bias words: 32 channel biases, then rescale multiplier, then shift
OUT_BEATS, 32, conv valid beats expected per frame
TIMEOUT, 4095, maximum RUN cycles before abort (12-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_req  in  1  start-of-frame request, sampled in IDLE only
bias_reload  in  1  sampled with frame_req; 1 = load BIAS_WORDS bias words before the image
frame_busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on frame end (normal end or timeout)
err_timeout  out  1  sticky timeout flag; cleared by rst or an accepted frame_req
bias_valid  in  1  bias stream valid
bias_data  in  16  bias stream word
bias_ready  out  1  bias stream ready
pix_valid  in  1  image stream valid
pix_data  in  32  image word, pixel0 in bits [7:0]
pix_ready  out  1  image stream ready
scan_o  out  40  engine scan write: {word[31:0], 1'b0, ptr[6:0]}
bias_o  out  24  engine bias write: {word[15:0], 2'b0, ptr[5:0]}
sta_o  out  1  engine start
conv_valid_i  in  1  engine output valid
conv_data_i  in  320  engine output, 40 x int8
out_valid  out  1  forwarded output valid
out_data  out  320  forwarded output data
beat_cnt  out  6  beats received in the current frame

Behaviour:
- Reset values: scan_o ptr field 7'h7F, data 0; bias_o ptr field 6'h3F, data 0; all other outputs 0; state IDLE. The idle pointers lie outside both buffers, so the engine performs no write while the scheduler is idle. Reset mid-operation abandons the frame; buffer contents are left untouched.
- States: IDLE, LOAD_BIAS, LOAD_IMG, RUN, DONE.
- IDLE:
  - frame_req=1 with bias_reload=1 -> LOAD_BIAS.
  - frame_req=1 with bias_reload=0 -> LOAD_IMG.
  - Accepting frame_req clears err_timeout, beat_cnt and the word counter.
- LOAD_BIAS:
  - bias_ready=1.
  - Each handshake (bias_valid & bias_ready) registers bias_o={bias_data,2'b0,k}, where k is the word counter starting at 0. The write reaches the engine the following cycle.
  - After handshake k=BIAS_WORDS-1: word counter clears, state -> LOAD_IMG.
  - On cycles with no handshake, bias_o ptr returns to 6'h3F.
- LOAD_IMG: same rules on the pix interface. scan_o={pix_data,1'b0,k}; after k=IMG_WORDS-1, state -> RUN. Idle ptr 7'h7F.
- Only one stream is ready in any state. Data offered on the other stream is not consumed.
- RUN:
  - sta_o=1 from the first RUN cycle until the state exits RUN. Because the final buffer write lands on RUN cycle 0, the engine sees complete buffers when it samples sta.
  - Each conv_valid_i beat increments beat_cnt and forwards data: out_valid/out_data are registered, 1-cycle latency, no backpressure.
  - Beat number OUT_BEATS -> DONE; sta_o drops on the next cycle.
  - The RUN cycle counter reaching TIMEOUT before that -> err_timeout=1, then DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE. frame_busy is low from IDLE onward.
- conv_valid_i outside RUN is ignored: no forward, no count. One exception is the registered forward of the final RUN beat, which appears in the DONE cycle.
- frame_req while busy is ignored, not queued.
- Width rules: word counter is 7 bits; beat_cnt is 6 bits and saturates at 63; the timeout counter is 12 bits and saturates.

Test Plan:
- Reset: hold rst 2 cycles, then run idle 10 cycles -> scan_o ptr=7'h7F, bias_o ptr=6'h3F every cycle; sta_o=frame_busy=0.
- Full frame, bias_reload=1, both streams valid every cycle:
  - bias_o ptr steps 0..33 on consecutive cycles; bias word 33 equals bias_data.
  - scan_o ptr steps 0..74.
  - sta_o rises the cycle after scan ptr 74.
  - 32 conv beats are forwarded 1 cycle late.
  - frame_done pulses once; beat_cnt=32.
- Stream bubbles: pix_valid toggles 1/0 -> each pointer is written exactly once and in order; the ptr field reads 7'h7F on bubble cycles; total image writes=75.
- bias_reload=0 -> no bias_o writes (ptr stays 6'h3F); the frame goes straight to LOAD_IMG; bias_ready=0 throughout.
- Timeout: with TIMEOUT=100, provide only 5 conv beats -> err_timeout=1 at RUN cycle 100, frame_done pulses, beat_cnt=5. The next frame_req clears err_timeout.
- Interference:
  - frame_req during RUN is ignored.
  - conv_valid_i pulses in IDLE give out_valid=0.
  - rst asserted mid-LOAD_IMG returns to IDLE next cycle with idle pointers; a fresh frame then completes normally.
